seq_scan_ctrl: RTL and testbench

//   Sequencer for the serial sequence-detection datapath. Accepts parallel words over a valid/ready

---
 rtl/seq_scan_pkg.sv | 18 +
 rtl/seq_window_match.sv | 40 ++++
 rtl/seq_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_seq_scan_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_scan_pkg.sv
// Shared types and defaults for the serial sequence-scan controller.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_PAT_W  = 3;

  // Width that can hold every value from 0 to data_w.
  function automatic int count_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/seq_window_match.sv
// Bit-history window and comparator for overlapping pattern detection.
// hit is combinational and qualified by bit_en; history and fill persist until rst or clr.
module seq_window_match import seq_scan_pkg::*; #(
  parameter int PAT_W = DEF_PAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_bit,
  input  logic             bit_en,
  input  logic [PAT_W-1:0] pattern,
  input  logic             clr,
  output logic             hit,
  output logic [PAT_W-2:0] history
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [FILL_W-1:0] fill;
  logic [PAT_W-1:0]  window_next;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    window_next = {history, scan_bit};
    hit         = bit_en && ((int'(fill) + 1) >= PAT_W) && (window_next == pattern);
  end

  // Only PAT_W-1 old bits are kept; the newest bit completes the window.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      history <= '0;
      fill    <= '0;
    end else if (bit_en) begin
      history <= window_next[PAT_W-2:0];
      if (int'(fill) < PAT_W) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Word-to-bit sequencer with overlapping pattern match and per-word match count.
// Optional sticky interrupt on non-zero results when SEQ_SCAN_IRQ_EN is defined.
module seq_scan_ctrl import seq_scan_pkg::*; #(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int PAT_W  = DEF_PAT_W,
  localparam int CNT_W  = count_width(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              flush,
  output logic              ser_bit,
  output logic              ser_valid,
  output logic              match,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count,
  input  logic              out_ready
`ifdef SEQ_SCAN_IRQ_EN
  ,
  input  logic              irq_clr,
  output logic              irq
`endif
);

  localparam int BCNT_W = $clog2(DATA_W);

  state_t              state;
  logic [DATA_W-1:0]   word;
  logic [PAT_W-1:0]    pat_q;
  logic [BCNT_W-1:0]   bit_cnt;
  logic [CNT_W-1:0]    count;
  logic [CNT_W-1:0]    count_next;
  logic                hit;
  logic                win_clr;
  logic [PAT_W-2:0]    history_unused;

  assign count_next = count + CNT_W'(hit);
  assign win_clr    = flush && (state == IDLE);

  // The window sees the bit currently on the serial output; ser_valid marks it as live.
  seq_window_match #(
    .PAT_W (PAT_W)
  ) u_match (
    .clk      (clk),
    .rst      (rst),
    .scan_bit (ser_bit),
    .bit_en   (ser_valid),
    .pattern  (pat_q),
    .clr      (win_clr),
    .hit      (hit),
    .history  (history_unused)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      ser_bit   <= 1'b0;
      ser_valid <= 1'b0;
      match     <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      word      <= '0;
      pat_q     <= '0;
      bit_cnt   <= '0;
      count     <= '0;
    end else begin
      match <= hit;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            // The MSB goes straight to ser_bit; word keeps the remaining bits left-aligned.
            ser_bit   <= in_data[DATA_W-1];
            ser_valid <= 1'b1;
            word      <= {in_data[DATA_W-2:0], 1'b0};
            pat_q     <= cfg_pattern;
            count     <= '0;
            bit_cnt   <= BCNT_W'(DATA_W - 1);
            in_ready  <= 1'b0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          count <= count_next;
          if (bit_cnt == '0) begin
            ser_bit   <= 1'b0;
            ser_valid <= 1'b0;
            out_valid <= 1'b1;
            out_count <= count_next;
            state     <= DONE;
          end else begin
            ser_bit <= word[DATA_W-1];
            word    <= {word[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - BCNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SEQ_SCAN_IRQ_EN
  // A completed non-zero result beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq <= 1'b0;
    end else if (out_valid && out_ready && (out_count != '0)) begin
      irq <= 1'b1;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: directed scenarios plus randomized words
// checked against a bit-stream model of overlapping pattern matches.
module tb_seq_scan_ctrl;

  localparam int DATA_W = 8;
  localparam int PAT_W  = 3;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic [PAT_W-1:0]  cfg_pattern;
  logic              flush;
  logic              ser_bit;
  logic              ser_valid;
  logic              match;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;
`ifdef SEQ_SCAN_IRQ_EN
  logic              irq_clr;
  logic              irq;
  logic              irq_exp;
  logic              hs_clr;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  // Every bit serialized since the last reset/flush, oldest first (trimmed to PAT_W).
  logic stream[$];

  seq_scan_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .cfg_pattern (cfg_pattern),
    .flush       (flush),
    .ser_bit     (ser_bit),
    .ser_valid   (ser_valid),
    .match       (match),
    .out_valid   (out_valid),
    .out_count   (out_count),
    .out_ready   (out_ready)
`ifdef SEQ_SCAN_IRQ_EN
    ,
    .irq_clr     (irq_clr),
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Appends one bit; it matches when the last PAT_W bits, newest as LSB, equal pat.
  function automatic logic model_push(input logic b, input logic [PAT_W-1:0] pat);
    int unsigned v = 0;
    stream.push_back(b);
    if (stream.size() > PAT_W) void'(stream.pop_front());
    if (stream.size() < PAT_W) return 1'b0;
    foreach (stream[i]) v = v * 2 + int'(stream[i]);
    return v == int'(pat);
  endfunction

  task automatic do_flush;
    in_valid = 1'b0;
    flush    = 1'b1;
    stream.delete();
    tick();
    flush = 1'b0;
  endtask

  // Sends one word, checks the serial stream and result, returns the observed count.
  task automatic send_word(input logic [DATA_W-1:0] data, input logic [PAT_W-1:0] pat,
                           input bit flush_acc, input int flush_at, input int hold,
                           output int got_cnt);
    logic exp_m[DATA_W];
    int   exp_cnt = 0;
    if (flush_acc) stream.delete();
    for (int i = 0; i < DATA_W; i++) begin
      exp_m[i] = model_push(data[DATA_W-1-i], pat);
      exp_cnt += int'(exp_m[i]);
    end
    check("idle_in_ready", in_ready, 1'b1);
    in_valid    = 1'b1;
    in_data     = data;
    cfg_pattern = pat;
    flush       = flush_acc;
    tick();
    in_valid = 1'b0;
    flush    = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      cfg_pattern = PAT_W'($urandom);
      flush       = (i == flush_at);
      check("ser_valid", ser_valid, 1'b1);
      check("ser_bit", ser_bit, data[DATA_W-1-i]);
      check("match", match, (i == 0) ? 1'b0 : exp_m[i-1]);
      check("busy_in_ready", in_ready, 1'b0);
      check("busy_out_valid", out_valid, 1'b0);
      tick();
    end
    flush = 1'b0;
    check("done_out_valid", out_valid, 1'b1);
    check("done_out_count", out_count, exp_cnt);
    check("done_last_match", match, exp_m[DATA_W-1]);
    check("done_ser_valid", ser_valid, 1'b0);
    got_cnt = int'(out_count);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'($urandom);
      tick();
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_out_count", out_count, exp_cnt);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_ser_valid", ser_valid, 1'b0);
    end
`ifdef SEQ_SCAN_IRQ_EN
    irq_clr = hs_clr;
`endif
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("ret_out_valid", out_valid, 1'b0);
    check("ret_in_ready", in_ready, 1'b1);
    check("ret_ser_valid", ser_valid, 1'b0);
`ifdef SEQ_SCAN_IRQ_EN
    irq_clr = 1'b0;
    if (exp_cnt != 0) irq_exp = 1'b1;
    else if (hs_clr) irq_exp = 1'b0;
    check("irq_handshake", irq, irq_exp);
`endif
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    stream.delete();
`ifdef SEQ_SCAN_IRQ_EN
    irq_exp = 1'b0;
`endif
  endtask

  initial begin
    int cnt;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; cfg_pattern = '0;
    flush = 1'b0; out_ready = 1'b0;
`ifdef SEQ_SCAN_IRQ_EN
    irq_clr = 1'b0; hs_clr = 1'b0; irq_exp = 1'b0;
`endif
    apply_reset();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_ser_bit", ser_bit, 1'b0);
    check("rst_ser_valid", ser_valid, 1'b0);
    check("rst_match", match, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_count", out_count, 0);
`ifdef SEQ_SCAN_IRQ_EN
    check("rst_irq", irq, 1'b0);
`endif

    // Basic word with two overlapping matches.
    send_word(8'b1010_1000, 3'b101, 1'b0, -1, 0, cnt);
    check("t1_count", cnt, 2);

    // Cross-word overlap.
    do_flush();
    send_word(8'b0000_0010, 3'b101, 1'b0, -1, 0, cnt);
    check("t2_w1_count", cnt, 0);
    send_word(8'b1000_0000, 3'b101, 1'b0, -1, 0, cnt);
    check("t2_w2_count", cnt, 1);

    // Flush in IDLE breaks the overlap; flush mid-SHIFT does not.
    do_flush();
    send_word(8'b0000_0010, 3'b101, 1'b0, -1, 0, cnt);
    do_flush();
    send_word(8'b1000_0000, 3'b101, 1'b0, -1, 0, cnt);
    check("t3_flush_idle_count", cnt, 0);
    do_flush();
    send_word(8'b0000_0010, 3'b101, 1'b0, -1, 0, cnt);
    send_word(8'b1000_0000, 3'b101, 1'b0, 2, 0, cnt);
    check("t3_flush_shift_count", cnt, 1);

    // Flush coincident with accept starts from empty history.
    send_word(8'b0000_0010, 3'b101, 1'b0, -1, 0, cnt);
    send_word(8'b1000_0000, 3'b101, 1'b1, -1, 0, cnt);
    check("t3_flush_accept_count", cnt, 0);

    // Back-pressure in DONE with a pending word.
    send_word(8'b1010_1000, 3'b101, 1'b1, -1, 5, cnt);
    check("t4_count", cnt, 2);

    // Reset during the 4th SHIFT cycle.
    in_valid = 1'b1; in_data = 8'b1111_1111; cfg_pattern = 3'b111;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_pre_ser_valid", ser_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stream.delete();
`ifdef SEQ_SCAN_IRQ_EN
    irq_exp = 1'b0;
    check("t5_irq", irq, 1'b0);
`endif
    check("t5_ser_valid", ser_valid, 1'b0);
    check("t5_in_ready", in_ready, 1'b1);
    check("t5_out_valid", out_valid, 1'b0);
    check("t5_match", match, 1'b0);
    check("t5_history", dut.u_match.history, 0);
    tick();
    check("t5_no_result", out_valid, 1'b0);
    send_word(8'b1010_1000, 3'b101, 1'b0, -1, 0, cnt);
    check("t5_count", cnt, 2);

`ifdef SEQ_SCAN_IRQ_EN
    check("t6_irq_set", irq, 1'b1);
    irq_clr = 1'b1;
    tick();
    irq_clr = 1'b0;
    irq_exp = 1'b0;
    check("t6_irq_clr", irq, 1'b0);
    do_flush();
    send_word(8'b0000_0000, 3'b101, 1'b0, -1, 0, cnt);
    check("t6_irq_zero", irq, 1'b0);
    hs_clr = 1'b1;
    send_word(8'b1010_1000, 3'b101, 1'b1, -1, 1, cnt);
    hs_clr = 1'b0;
    check("t6_irq_set_wins", irq, 1'b1);
`endif

    // Randomized words, patterns, gaps, flushes and back-pressure.
    for (int n = 0; n < 40; n++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 4) == 0) do_flush();
        else tick();
      end
`ifdef SEQ_SCAN_IRQ_EN
      hs_clr = 1'($urandom_range(0, 1));
`endif
      send_word(DATA_W'($urandom), PAT_W'($urandom), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 15), $urandom_range(0, 3), cnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
